// File: rtl/multi_channel_scoreboard.sv
// multi_channel_scoreboard: per-channel in-order expected/actual checker with bypass, accounting and first-error capture
module multi_channel_scoreboard #(
  parameter int CHANNELS = 2,
  parameter int ENTRIES = 100,
  parameter int BITS = 16,
  parameter bit ERR_MSG = 1'b1,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int PW = $clog2(CHANNELS * ENTRIES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exp_en,
  input  logic [CW-1:0]   exp_chan,
  input  logic [BITS-1:0] exp_data,
  input  logic            act_en,
  input  logic [CW-1:0]   act_chan,
  input  logic [BITS-1:0] act_data,
  output logic [31:0]     matched,
  output logic [31:0]     mismatched,
  output logic [31:0]     unexpected,
  output logic [31:0]     overflowed,
  output logic [PW-1:0]   pending,
  output logic            drained,
  output logic            err_valid,
  output logic [CW-1:0]   err_chan,
  output logic [BITS-1:0] err_exp,
  output logic [BITS-1:0] err_act
);
  localparam int EW = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
  localparam int NW = $clog2(ENTRIES + 1);
  if (CHANNELS < 1 || ENTRIES < 1 || BITS < 1) begin : g_bad_params
    $error("multi_channel_scoreboard: CHANNELS, ENTRIES and BITS must be at least 1");
  end
  logic [NW-1:0]   w_cnt [CHANNELS];
  logic [BITS-1:0] w_head [CHANNELS];
  logic            w_exp_ok, w_act_ok, w_pop, w_bypass, w_unexp, w_same, w_ovf, w_push, w_cmp, w_eq;
  logic [BITS-1:0] w_ref;
  logic [31:0]     r_matched, r_mismatched, r_unexpected, r_overflowed;
  logic [PW-1:0]   r_pending;
  logic            r_err_valid;
  logic [CW-1:0]   r_err_chan;
  logic [BITS-1:0] r_err_exp, r_err_act;
  function automatic logic [EW-1:0] f_next(input logic [EW-1:0] p);
    return p == EW'(ENTRIES - 1) ? '0 : p + 1'b1;
  endfunction
  // Decode this cycle's pop, bypass, push and accounting events from start-of-cycle counts
  always_comb begin
    w_exp_ok = exp_en && {1'b0, exp_chan} < (CW + 1)'(CHANNELS);
    w_act_ok = act_en && {1'b0, act_chan} < (CW + 1)'(CHANNELS);
    w_pop    = w_act_ok && w_cnt[act_chan] != '0;
    w_bypass = w_act_ok && w_cnt[act_chan] == '0 && w_exp_ok && exp_chan == act_chan;
    w_unexp  = w_act_ok && w_cnt[act_chan] == '0 && !w_bypass;
    w_same   = w_pop && exp_chan == act_chan;
    w_ovf    = w_exp_ok && !w_bypass && w_cnt[exp_chan] == NW'(ENTRIES) && !w_same;
    w_push   = w_exp_ok && !w_bypass && !w_ovf;
    w_cmp    = w_pop || w_bypass;
    w_ref    = w_pop ? w_head[act_chan] : exp_data;
    w_eq     = act_data == w_ref;
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [BITS-1:0] r_mem [ENTRIES];
    logic [EW-1:0]   r_rd, r_wr;
    logic [NW-1:0]   r_cnt;
    logic            w_pu, w_po;
    assign w_pu      = w_push && exp_chan == CW'(g);
    assign w_po      = w_pop && act_chan == CW'(g);
    assign w_cnt[g]  = r_cnt;
    assign w_head[g] = r_mem[r_rd];
    // Circular FIFO storage, wrapping pointers and occupancy for one channel
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_pu) begin
          r_mem[r_wr] <= exp_data;
          r_wr        <= f_next(r_wr);
        end
        if (w_po) r_rd <= f_next(r_rd);
        r_cnt <= r_cnt + NW'(w_pu) - NW'(w_po);
      end
    end
  end
  // Saturating event counters, total occupancy and first-mismatch capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_matched    <= '0;
      r_mismatched <= '0;
      r_unexpected <= '0;
      r_overflowed <= '0;
      r_pending    <= '0;
      r_err_valid  <= 1'b0;
      r_err_chan   <= '0;
      r_err_exp    <= '0;
      r_err_act    <= '0;
    end else begin
      if (w_cmp && w_eq && r_matched != '1) r_matched <= r_matched + 32'd1;
      if (w_cmp && !w_eq && r_mismatched != '1) r_mismatched <= r_mismatched + 32'd1;
      if (w_unexp && r_unexpected != '1) r_unexpected <= r_unexpected + 32'd1;
      if (w_ovf && r_overflowed != '1) r_overflowed <= r_overflowed + 32'd1;
      r_pending <= r_pending + PW'(w_push) - PW'(w_pop);
      if (w_cmp && !w_eq && !r_err_valid) begin
        r_err_valid <= 1'b1;
        r_err_chan  <= act_chan;
        r_err_exp   <= w_ref;
        r_err_act   <= act_data;
      end
    end
  end
  // Simulation diagnostics for ignored, dropped, unmatched and mismatching traffic
  always_ff @(posedge clk) begin
    if (ERR_MSG && !rst) begin
      if ((exp_en && !w_exp_ok) || (act_en && !w_act_ok)) $error("scoreboard: out-of-range channel ignored");
      if (w_ovf) $error("scoreboard: overflow on channel %0d, value %h dropped", exp_chan, exp_data);
      if (w_unexp) $error("scoreboard: unexpected actual %h on channel %0d", act_data, act_chan);
      if (w_cmp && !w_eq) $error("scoreboard: mismatch on channel %0d exp %h act %h", act_chan, w_ref, act_data);
    end
  end
  assign matched    = r_matched;
  assign mismatched = r_mismatched;
  assign unexpected = r_unexpected;
  assign overflowed = r_overflowed;
  assign pending    = r_pending;
  assign drained    = r_pending == '0;
  assign err_valid  = r_err_valid;
  assign err_chan   = r_err_chan;
  assign err_exp    = r_err_exp;
  assign err_act    = r_err_act;
endmodule

// File: tb/tb_multi_channel_scoreboard.sv
// tb_multi_channel_scoreboard: directed table plus randomized queue-model check of the scoreboard
module tb_multi_channel_scoreboard;
  localparam int CH = 3;
  localparam int ENT = 4;
  localparam int B = 16;
  localparam int CW = 2;
  localparam int PW = $clog2(CH * ENT + 1);
  logic clk = 1'b0;
  logic rst;
  logic exp_en, act_en;
  logic [CW-1:0] exp_chan, act_chan;
  logic [B-1:0] exp_data, act_data;
  logic [31:0] matched, mismatched, unexpected, overflowed;
  logic [PW-1:0] pending;
  logic drained, err_valid;
  logic [CW-1:0] err_chan;
  logic [B-1:0] err_exp, err_act;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  multi_channel_scoreboard #(.CHANNELS(CH), .ENTRIES(ENT), .BITS(B), .ERR_MSG(1'b0)) dut (
    .clk(clk), .rst(rst),
    .exp_en(exp_en), .exp_chan(exp_chan), .exp_data(exp_data),
    .act_en(act_en), .act_chan(act_chan), .act_data(act_data),
    .matched(matched), .mismatched(mismatched), .unexpected(unexpected), .overflowed(overflowed),
    .pending(pending), .drained(drained),
    .err_valid(err_valid), .err_chan(err_chan), .err_exp(err_exp), .err_act(err_act)
  );
  typedef struct {
    bit ee; int ec; logic [B-1:0] ed;
    bit ae; int ac; logic [B-1:0] ad;
    int m, mm, u, o, p;
  } vec_t;
  vec_t tv[24];
  logic [B-1:0] q[CH][$];
  int m_m, m_mm, m_u, m_o, m_ec;
  bit m_ev;
  logic [B-1:0] m_ee, m_ea;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < CH; c++) q[c].delete();
    m_m = 0; m_mm = 0; m_u = 0; m_o = 0; m_ev = 0; m_ec = 0; m_ee = '0; m_ea = '0;
  endtask
  task automatic model(input bit ee, input int ec, input logic [B-1:0] ed, input bit ae, input int ac, input logic [B-1:0] ad);
    bit ev, av, pop, byp, cmp;
    logic [B-1:0] r;
    ev = ee && ec < CH; av = ae && ac < CH; pop = 0; byp = 0; cmp = 0; r = '0;
    if (av) begin
      if (q[ac].size() > 0) begin r = q[ac][0]; pop = 1; cmp = 1; end
      else if (ev && ec == ac) begin r = ed; byp = 1; cmp = 1; end
      else m_u++;
    end
    if (pop) void'(q[ac].pop_front());
    if (ev && !byp) begin
      if (q[ec].size() < ENT) q[ec].push_back(ed);
      else m_o++;
    end
    if (cmp) begin
      if (r == ad) m_m++;
      else begin
        m_mm++;
        if (!m_ev) begin m_ev = 1; m_ec = ac; m_ee = r; m_ea = ad; end
      end
    end
  endtask
  function automatic int model_pending();
    int s = 0;
    for (int c = 0; c < CH; c++) s += q[c].size();
    return s;
  endfunction
  task automatic drive(input bit ee, input int ec, input logic [B-1:0] ed, input bit ae, input int ac, input logic [B-1:0] ad);
    exp_en = ee; exp_chan = CW'(ec); exp_data = ed;
    act_en = ae; act_chan = CW'(ac); act_data = ad;
    model(ee, ec, ed, ae, ac, ad);
    @(posedge clk);
    #1;
    exp_en = 0; act_en = 0;
  endtask
  task automatic cmp_model(input string n);
    chk({n, " matched"}, 64'(matched), 64'(m_m));
    chk({n, " mismatched"}, 64'(mismatched), 64'(m_mm));
    chk({n, " unexpected"}, 64'(unexpected), 64'(m_u));
    chk({n, " overflowed"}, 64'(overflowed), 64'(m_o));
    chk({n, " pending"}, 64'(pending), 64'(model_pending()));
    chk({n, " drained"}, 64'(drained), 64'(model_pending() == 0));
    chk({n, " err_valid"}, 64'(err_valid), 64'(m_ev));
    if (m_ev) begin
      chk({n, " err_chan"}, 64'(err_chan), 64'(m_ec));
      chk({n, " err_exp"}, 64'(err_exp), 64'(m_ee));
      chk({n, " err_act"}, 64'(err_act), 64'(m_ea));
    end
  endtask
  task automatic chk_reset_state(input string n);
    chk({n, " matched"}, 64'(matched), 0);
    chk({n, " mismatched"}, 64'(mismatched), 0);
    chk({n, " unexpected"}, 64'(unexpected), 0);
    chk({n, " overflowed"}, 64'(overflowed), 0);
    chk({n, " pending"}, 64'(pending), 0);
    chk({n, " drained"}, 64'(drained), 1);
    chk({n, " err_valid"}, 64'(err_valid), 0);
    chk({n, " err_chan"}, 64'(err_chan), 0);
    chk({n, " err_exp"}, 64'(err_exp), 0);
    chk({n, " err_act"}, 64'(err_act), 0);
  endtask
  initial begin
    logic [B-1:0] s[2][50];
    int pi[2], ai[2];
    tv[0]  = '{1, 0, 16'h0011, 0, 0, 16'h0000, 0, 0, 0, 0, 1};
    tv[1]  = '{1, 0, 16'h0022, 0, 0, 16'h0000, 0, 0, 0, 0, 2};
    tv[2]  = '{0, 0, 16'h0000, 1, 0, 16'h0011, 1, 0, 0, 0, 1};
    tv[3]  = '{0, 0, 16'h0000, 1, 0, 16'h0022, 2, 0, 0, 0, 0};
    tv[4]  = '{1, 1, 16'h00AA, 0, 0, 16'h0000, 2, 0, 0, 0, 1};
    tv[5]  = '{0, 0, 16'h0000, 1, 1, 16'h00AB, 2, 1, 0, 0, 0};
    tv[6]  = '{1, 0, 16'h0055, 0, 0, 16'h0000, 2, 1, 0, 0, 1};
    tv[7]  = '{0, 0, 16'h0000, 1, 0, 16'h0056, 2, 2, 0, 0, 0};
    tv[8]  = '{1, 0, 16'h0001, 0, 0, 16'h0000, 2, 2, 0, 0, 1};
    tv[9]  = '{1, 0, 16'h0002, 0, 0, 16'h0000, 2, 2, 0, 0, 2};
    tv[10] = '{1, 0, 16'h0003, 0, 0, 16'h0000, 2, 2, 0, 0, 3};
    tv[11] = '{1, 0, 16'h0004, 0, 0, 16'h0000, 2, 2, 0, 0, 4};
    tv[12] = '{1, 0, 16'h0005, 0, 0, 16'h0000, 2, 2, 0, 1, 4};
    tv[13] = '{1, 0, 16'h0006, 1, 0, 16'h0001, 3, 2, 0, 1, 4};
    tv[14] = '{0, 0, 16'h0000, 1, 0, 16'h0002, 4, 2, 0, 1, 3};
    tv[15] = '{0, 0, 16'h0000, 1, 0, 16'h0003, 5, 2, 0, 1, 2};
    tv[16] = '{0, 0, 16'h0000, 1, 0, 16'h0004, 6, 2, 0, 1, 1};
    tv[17] = '{0, 0, 16'h0000, 1, 0, 16'h0006, 7, 2, 0, 1, 0};
    tv[18] = '{0, 0, 16'h0000, 1, 1, 16'h0077, 7, 2, 1, 1, 0};
    tv[19] = '{1, 0, 16'h0033, 1, 0, 16'h0033, 8, 2, 1, 1, 0};
    tv[20] = '{1, 2, 16'h0010, 1, 2, 16'h0011, 8, 3, 1, 1, 0};
    tv[21] = '{1, 3, 16'h0099, 1, 3, 16'h0099, 8, 3, 1, 1, 0};
    tv[22] = '{1, 1, 16'h0044, 1, 0, 16'h0044, 8, 3, 2, 1, 1};
    tv[23] = '{0, 0, 16'h0000, 1, 1, 16'h0044, 9, 3, 2, 1, 0};
    rst = 1; exp_en = 0; act_en = 0; exp_chan = 0; act_chan = 0; exp_data = 0; act_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 0;
    for (int i = 0; i < 24; i++) begin
      drive(tv[i].ee, tv[i].ec, tv[i].ed, tv[i].ae, tv[i].ac, tv[i].ad);
      chk($sformatf("row%0d matched", i), 64'(matched), 64'(tv[i].m));
      chk($sformatf("row%0d mismatched", i), 64'(mismatched), 64'(tv[i].mm));
      chk($sformatf("row%0d unexpected", i), 64'(unexpected), 64'(tv[i].u));
      chk($sformatf("row%0d overflowed", i), 64'(overflowed), 64'(tv[i].o));
      chk($sformatf("row%0d pending", i), 64'(pending), 64'(tv[i].p));
      chk($sformatf("row%0d drained", i), 64'(drained), 64'(tv[i].p == 0));
      chk($sformatf("row%0d err_valid", i), 64'(err_valid), 64'(i >= 5));
      if (i >= 5) begin
        chk($sformatf("row%0d err_chan", i), 64'(err_chan), 1);
        chk($sformatf("row%0d err_exp", i), 64'(err_exp), 64'h00AA);
        chk($sformatf("row%0d err_act", i), 64'(err_act), 64'h00AB);
      end
    end
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    rst = 0;
    chk_reset_state("reset2");
    for (int c = 0; c < 2; c++) begin
      pi[c] = 0; ai[c] = 0;
      for (int k = 0; k < 50; k++) s[c][k] = B'($urandom);
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      bit ee, ae;
      int ec, ac;
      logic [B-1:0] ed, ad;
      if (cyc == 150) begin
        rst = 1;
        drive(1, 0, 16'h1234, 1, 1, 16'h5678);
        model_reset();
        rst = 0;
        chk_reset_state("midreset");
      end
      ec = $urandom_range(0, 1); ac = $urandom_range(0, 1);
      ee = pi[ec] < 50 && $urandom_range(0, 1) == 1;
      ae = ai[ac] < 50 && $urandom_range(0, 1) == 1;
      ed = ee ? s[ec][pi[ec]] : B'(0);
      ad = ae ? s[ac][ai[ac]] ^ B'($urandom_range(0, 9) == 0) : B'(0);
      if (ee) pi[ec]++;
      if (ae) ai[ac]++;
      drive(ee, ec, ed, ae, ac, ad);
      cmp_model($sformatf("rand%0d", cyc));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
